// File: rtl/rob_exception_controller.sv
// rob_exception_controller: sequences ROB-head exceptions, IRET and MOVRM into privileged writes, nuke and redirect (optional ROB_EXC_CAUSE_SAVE_EN adds an rm2 cause save)
module rob_exception_controller #(
   parameter logic [31:0] HANDLER_PC       = 32'h0000_2000,
   parameter int unsigned RM_IDX_W         = 3,
   parameter logic [2:0]  INSTR_TYPE_IRET  = 3'd4,
   parameter logic [2:0]  INSTR_TYPE_MOVRM = 3'd5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_head_valid,
   input  logic                in_head_complete,
   input  logic [2:0]          in_head_exception,
   input  logic [2:0]          in_head_instr_type,
   input  logic [31:0]         in_head_PC,
   input  logic [31:0]         in_head_miss_addr,
   input  logic [4:0]          in_head_rd,
   input  logic [31:0]         in_head_value,
   input  logic                in_stall,
   input  logic [31:0]         in_rm0_value,
   input  logic                in_redirect_ready,
   output logic                out_hold,
   output logic                out_head_retire,
   output logic                out_priv_write_enable,
   output logic [RM_IDX_W-1:0] out_priv_rm_idx,
   output logic [31:0]         out_priv_write_data,
   output logic                out_rob_nuke,
   output logic                out_redirect_valid,
   output logic [31:0]         out_redirect_pc,
   output logic                out_busy
);
   typedef enum logic [3:0] {
      IDLE, SAVE_PC, SAVE_ADDR,
`ifdef ROB_EXC_CAUSE_SAVE_EN
      SAVE_CAUSE,
`endif
      SET_PRIV, SET_USER, FLUSH, REDIRECT, MOVRM
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         pc_q, pc_d, addr_q, addr_d, value_q, value_d, rm0_q, rm0_d;
   logic [2:0]          exc_q, exc_d;
   logic [RM_IDX_W-1:0] rd_q, rd_d;
   logic                iret_q, iret_d;
   logic                is_exc, is_iret, is_movrm, trigger, unused_bits;

   assign is_exc      = in_head_exception != 3'd0;
   assign is_iret     = in_head_instr_type == INSTR_TYPE_IRET;
   assign is_movrm    = in_head_instr_type == INSTR_TYPE_MOVRM;
   assign trigger     = reset && state_q == IDLE && in_head_valid && in_head_complete && !in_stall
                        && (is_exc || is_iret || is_movrm);
   assign unused_bits = ^{in_head_rd, exc_q};
   assign out_busy    = state_q != IDLE;
   assign out_hold    = out_busy || trigger;

   // Next state; head operands are captured only in the trigger cycle and ignored afterwards
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      value_d = value_q;
      rm0_d   = rm0_q;
      exc_d   = exc_q;
      rd_d    = rd_q;
      iret_d  = iret_q;
      if (trigger) begin
         pc_d    = in_head_PC;
         addr_d  = in_head_miss_addr;
         value_d = in_head_value;
         rm0_d   = in_rm0_value;
         exc_d   = in_head_exception;
         rd_d    = in_head_rd[RM_IDX_W-1:0];
         iret_d  = !is_exc && is_iret;
      end
      case (state_q)
         IDLE:       state_d = !trigger ? IDLE : is_exc ? SAVE_PC : is_iret ? SET_USER : MOVRM;
         SAVE_PC:    state_d = SAVE_ADDR;
`ifdef ROB_EXC_CAUSE_SAVE_EN
         SAVE_ADDR:  state_d = SAVE_CAUSE;
         SAVE_CAUSE: state_d = SET_PRIV;
`else
         SAVE_ADDR:  state_d = SET_PRIV;
`endif
         SET_PRIV:   state_d = FLUSH;
         SET_USER:   state_d = FLUSH;
         FLUSH:      state_d = REDIRECT;
         REDIRECT:   state_d = in_redirect_ready ? IDLE : REDIRECT;
         MOVRM:      state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // State and latched head operands; active-low reset aborts any sequence in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         addr_q  <= '0;
         value_q <= '0;
         rm0_q   <= '0;
         exc_q   <= '0;
         rd_q    <= '0;
         iret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         value_q <= value_d;
         rm0_q   <= rm0_d;
         exc_q   <= exc_d;
         rd_q    <= rd_d;
         iret_q  <= iret_d;
      end
   end

   // Outputs decoded from the registered state; write data is forced to zero when not writing
   always_comb begin
      out_head_retire       = 1'b0;
      out_priv_write_enable = 1'b0;
      out_priv_rm_idx       = '0;
      out_priv_write_data   = '0;
      out_rob_nuke          = 1'b0;
      out_redirect_valid    = 1'b0;
      out_redirect_pc       = '0;
      case (state_q)
         SAVE_PC: begin
            out_priv_write_enable = 1'b1;
            out_priv_write_data   = pc_q;
         end
         SAVE_ADDR: begin
            out_priv_write_enable = 1'b1;
            out_priv_rm_idx       = RM_IDX_W'(1);
            out_priv_write_data   = addr_q;
         end
`ifdef ROB_EXC_CAUSE_SAVE_EN
         SAVE_CAUSE: begin
            out_priv_write_enable = 1'b1;
            out_priv_rm_idx       = RM_IDX_W'(2);
            out_priv_write_data   = {29'b0, exc_q};
         end
`endif
         SET_PRIV: begin
            out_priv_write_enable = 1'b1;
            out_priv_rm_idx       = RM_IDX_W'(4);
            out_priv_write_data   = 32'h1;
         end
         SET_USER: begin
            out_priv_write_enable = 1'b1;
            out_priv_rm_idx       = RM_IDX_W'(4);
         end
         FLUSH:    out_rob_nuke = 1'b1;
         REDIRECT: begin
            out_redirect_valid = 1'b1;
            out_redirect_pc    = iret_q ? rm0_q : HANDLER_PC;
         end
         MOVRM: begin
            out_head_retire       = 1'b1;
            out_priv_write_enable = 1'b1;
            out_priv_rm_idx       = rd_q;
            out_priv_write_data   = value_q;
         end
         default: out_head_retire = 1'b0;
      endcase
   end
endmodule
